// File: rtl/idelay_ctrl_pkg.sv
// Shared definitions for the multi-channel IDELAY step sequencer:
// state encoding, default parameter values and channel-slice helper.
package idelay_ctrl_pkg;

  localparam int unsigned N_CH_DEF      = 4;
  localparam int unsigned DW_DEF        = 9;
  localparam int unsigned MAX_STEP_DEF  = 8;
  localparam int unsigned WAIT_CYC_DEF  = 4;
  localparam int unsigned ERR_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CAPTURE,
    CALC,
    WRITE,
    SETTLE,
    VERIFY
  } state_t;

  // Bit offset of channel ch inside a packed N_CH*DW bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/idelay_step_calc.sv
// Combinational clamp: next tap value moves from cur toward tgt by at most
// MAX_STEP taps (MAX_STEP=0 jumps straight to tgt).
module idelay_step_calc #(
  parameter int unsigned DW       = 9,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic [DW-1:0] i_cur,
  input  logic [DW-1:0] i_tgt,
  output logic [DW-1:0] o_nxt
);

  localparam logic signed [DW:0] STEP_S = (DW+1)'(MAX_STEP);
  localparam logic        [DW-1:0] STEP_U = DW'(MAX_STEP);

  logic signed [DW:0] w_diff;

  always_comb begin
    w_diff = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
    o_nxt  = i_tgt;
    if (MAX_STEP != 0) begin
      if (w_diff > STEP_S) begin
        o_nxt = i_cur + STEP_U;
      end else if (w_diff < -STEP_S) begin
        o_nxt = i_cur - STEP_U;
      end
    end
  end

endmodule

// File: rtl/idelay_multi_set_ctrl.sv
// Round-robin IDELAY tap sequencer: steps each channel toward its target,
// strobes LOAD, waits to settle, verifies readback and flags stalled channels.
module idelay_multi_set_ctrl
  import idelay_ctrl_pkg::*;
#(
  parameter int unsigned N_CH      = N_CH_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_STEP  = MAX_STEP_DEF,
  parameter int unsigned WAIT_CYC  = WAIT_CYC_DEF,
  parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic               clk160,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_CH*DW-1:0] delay_target,
  input  logic [N_CH*DW-1:0] delay_out,
  output logic [N_CH*DW-1:0] delay_set_value,
  output logic [N_CH-1:0]    delay_wr,
  output logic [N_CH-1:0]    ch_ready,
  output logic               all_ready,
  output logic [N_CH-1:0]    ch_error,
  output logic               busy
);

  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SW = $clog2(ERR_LIMIT + 1);
  localparam int unsigned CW = $clog2(WAIT_CYC + 1);

  state_t              r_state, w_next;
  logic [PW-1:0]       r_ptr;
  logic [DW-1:0]       r_cur, r_tgt;
  logic [CW-1:0]       r_cnt;
  logic                r_supp;
  logic [N_CH*DW-1:0]  r_set;
  logic [N_CH-1:0]     r_wr, r_err;
  logic                r_busy;
  logic [SW-1:0]       r_stall   [N_CH];
  logic [DW-1:0]       r_err_tgt [N_CH];

  logic [DW-1:0]       w_tgt [N_CH];
  logic [DW-1:0]       w_out [N_CH];
  logic [N_CH-1:0]     w_ready;
  logic [DW-1:0]       w_sel_tgt, w_sel_out, w_sel_set, w_nxt;
  logic                w_sel_ready, w_sel_err, w_pending;
  logic [PW-1:0]       w_ptr_nxt;

  // Channel selection is a compare-per-channel mux so the pointer width never
  // has to match the array index width (matters for N_CH=1 or non-power-of-2).
  always_comb begin
    w_sel_tgt   = '0;
    w_sel_out   = '0;
    w_sel_set   = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_tgt[c]   = delay_target[ch_lsb(c, DW) +: DW];
      w_out[c]   = delay_out[ch_lsb(c, DW) +: DW];
      w_ready[c] = (w_tgt[c] == w_out[c]);
      if (r_ptr == PW'(c)) begin
        w_sel_tgt   = w_tgt[c];
        w_sel_out   = w_out[c];
        w_sel_set   = r_set[ch_lsb(c, DW) +: DW];
        w_sel_ready = w_ready[c];
        w_sel_err   = r_err[c];
      end
    end
  end

  // Only leave IDLE when some channel needs work, so busy drops to 0 once settled.
  assign w_pending = |(~w_ready & ~r_err);
  assign w_ptr_nxt = (r_ptr == PW'(N_CH - 1)) ? '0 : r_ptr + PW'(1);

  idelay_step_calc #(
    .DW       (DW),
    .MAX_STEP (MAX_STEP)
  ) u_step_calc (
    .i_cur (r_cur),
    .i_tgt (r_tgt),
    .o_nxt (w_nxt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable && w_pending) w_next = SCAN;
      SCAN:    w_next = (w_sel_ready || w_sel_err) ? IDLE : CAPTURE;
      CAPTURE: w_next = CALC;
      CALC:    w_next = WRITE;
      WRITE:   w_next = SETTLE;
      SETTLE:  if (r_cnt == CW'(WAIT_CYC - 1)) w_next = VERIFY;
      VERIFY:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_supp  <= 1'b0;
      r_set   <= '0;
      r_wr    <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_stall[c]   <= '0;
        r_err_tgt[c] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_wr    <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (r_err[c] && (w_tgt[c] != r_err_tgt[c])) r_err[c] <= 1'b0;
      end
      case (r_state)
        SCAN: if (w_sel_ready || w_sel_err) r_ptr <= w_ptr_nxt;
        CAPTURE: begin
          r_cur <= w_sel_out;
          r_tgt <= w_sel_tgt;
        end
        CALC: begin
          r_cnt  <= '0;
          r_supp <= w_sel_ready;
          for (int unsigned c = 0; c < N_CH; c++) begin
            if (r_ptr == PW'(c)) begin
              r_set[ch_lsb(c, DW) +: DW] <= w_nxt;
              r_wr[c] <= ~w_sel_ready;
            end
          end
        end
        SETTLE: r_cnt <= r_cnt + CW'(1);
        VERIFY: begin
          r_ptr <= w_ptr_nxt;
          for (int unsigned c = 0; c < N_CH; c++) begin
            if (r_ptr == PW'(c)) begin
              if ((w_sel_out == w_sel_set) || r_supp) begin
                r_stall[c] <= '0;
              end else if (r_stall[c] == SW'(ERR_LIMIT - 1)) begin
                r_stall[c]   <= '0;
                r_err[c]     <= 1'b1;
                r_err_tgt[c] <= r_tgt;
              end else begin
                r_stall[c] <= r_stall[c] + SW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign delay_set_value = r_set;
  assign delay_wr        = r_wr;
  assign ch_ready        = w_ready;
  assign all_ready       = &w_ready;
  assign ch_error        = r_err;
  assign busy            = r_busy;

endmodule

// File: tb/tb_idelay_multi_set_ctrl.sv
// Directed bench for idelay_multi_set_ctrl: three instances (single channel,
// four channel, unlimited step) driven with hand-computed expectations.
module tb_idelay_multi_set_ctrl;

  localparam int DW = 9;

  logic clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  // single channel, MAX_STEP=8
  logic          en1;
  logic [DW-1:0] tgt1, set1;
  logic [DW-1:0] d1_1 = '0, out1 = '0;
  logic [0:0]    wr1, rdy1, err1;
  logic          ardy1, busy1;

  // four channels, MAX_STEP=8
  logic            en4;
  logic [4*DW-1:0] tgt4, set4, out4;
  logic [4*DW-1:0] d1_4 = '0, d2_4 = '0;
  logic [3:0]      wr4, rdy4, err4, stuck4;
  logic            ardy4, busy4;

  // single channel, MAX_STEP=0
  logic          en0;
  logic [DW-1:0] tgt0, set0;
  logic [DW-1:0] d1_0 = '0, out0 = '0;
  logic [0:0]    wr0, rdy0, err0;
  logic          ardy0, busy0;

  idelay_multi_set_ctrl #(
    .N_CH(1), .DW(DW), .MAX_STEP(8), .WAIT_CYC(4), .ERR_LIMIT(4)
  ) u_dut1 (
    .clk160(clk160), .rst(rst), .enable(en1), .delay_target(tgt1),
    .delay_out(out1), .delay_set_value(set1), .delay_wr(wr1),
    .ch_ready(rdy1), .all_ready(ardy1), .ch_error(err1), .busy(busy1)
  );

  idelay_multi_set_ctrl #(
    .N_CH(4), .DW(DW), .MAX_STEP(8), .WAIT_CYC(4), .ERR_LIMIT(4)
  ) u_dut4 (
    .clk160(clk160), .rst(rst), .enable(en4), .delay_target(tgt4),
    .delay_out(out4), .delay_set_value(set4), .delay_wr(wr4),
    .ch_ready(rdy4), .all_ready(ardy4), .ch_error(err4), .busy(busy4)
  );

  idelay_multi_set_ctrl #(
    .N_CH(1), .DW(DW), .MAX_STEP(0), .WAIT_CYC(4), .ERR_LIMIT(4)
  ) u_dut0 (
    .clk160(clk160), .rst(rst), .enable(en0), .delay_target(tgt0),
    .delay_out(out0), .delay_set_value(set0), .delay_wr(wr0),
    .ch_ready(rdy0), .all_ready(ardy0), .ch_error(err0), .busy(busy0)
  );

  // IDELAY model: readback follows the loaded value two cycles later.
  always @(posedge clk160) begin
    d1_1 <= set1; out1 <= d1_1;
    d1_0 <= set0; out0 <= d1_0;
    d1_4 <= set4; d2_4 <= d1_4;
  end

  always_comb begin
    out4 = d2_4;
    for (int c = 0; c < 4; c++) begin
      if (stuck4[c]) out4[c*DW +: DW] = '0;
    end
  end

  int q1[$], q0[$], q4c[$], q4v[$];
  int multi_wr = 0;

  always @(negedge clk160) begin
    if (wr1[0]) q1.push_back(int'(set1));
    if (wr0[0]) q0.push_back(int'(set0));
    if ($countones(wr4) > 1) multi_wr++;
    for (int c = 0; c < 4; c++) begin
      if (wr4[c]) begin
        q4c.push_back(c);
        q4v.push_back(int'(set4[c*DW +: DW]));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // which: 0 dut1 done, 1 dut4 done, 2 dut0 done, 3 dut4 ch0 error, 4 q4 holds >= need, 5 dut4 strobe
  task automatic wait_for(input int which, input int need, input int maxc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk160);
      case (which)
        0: ok = ardy1 && !busy1;
        1: ok = ardy4 && !busy4;
        2: ok = ardy0 && !busy0;
        3: ok = err4[0];
        4: ok = (q4c.size() >= need);
        default: ok = (wr4 != 4'b0);
      endcase
      if (ok) break;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int exp_c[6];
    int exp_v[6];
    rst = 1'b1; en1 = 1'b0; en4 = 1'b0; en0 = 1'b0;
    tgt1 = '0; tgt4 = '0; tgt0 = '0; stuck4 = '0;
    repeat (3) @(negedge clk160);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_wr4",   64'(wr4),   64'd0);
    check("rst_set4",  64'(set4),  64'd0);
    check("rst_err4",  64'(err4),  64'd0);
    check("rst_ardy4", 64'(ardy4), 64'd1);
    rst = 1'b0;

    // 0 -> 20 in clamped steps
    q1.delete();
    tgt1 = 9'd20; en1 = 1'b1;
    wait_for(0, 0, 200, "t1_done");
    check("t1_npulse", 64'(q1.size()), 64'd3);
    check("t1_p0", 64'(qget(q1, 0)), 64'd8);
    check("t1_p1", 64'(qget(q1, 1)), 64'd16);
    check("t1_p2", 64'(qget(q1, 2)), 64'd20);
    repeat (10) @(negedge clk160);
    check("t1_busy_idle", 64'(busy1), 64'd0);
    check("t1_npulse_hold", 64'(q1.size()), 64'd3);
    check("t1_set", 64'(set1), 64'd20);

    // 100 -> 95 in one step
    tgt1 = 9'd100;
    wait_for(0, 0, 400, "t2_ramp");
    q1.delete();
    tgt1 = 9'd95;
    wait_for(0, 0, 100, "t2_done");
    check("t2_npulse", 64'(q1.size()), 64'd1);
    check("t2_p0", 64'(qget(q1, 0)), 64'd95);
    check("t2_err", 64'(err1), 64'd0);
    en1 = 1'b0;

    // unlimited step
    q0.delete();
    tgt0 = 9'd300; en0 = 1'b1;
    wait_for(2, 0, 100, "t5_done");
    check("t5_npulse", 64'(q0.size()), 64'd1);
    check("t5_p0", 64'(qget(q0, 0)), 64'd300);
    en0 = 1'b0;

    // round-robin over four channels, targets {10,0,30,0}
    q4c.delete(); q4v.delete();
    tgt4 = {9'd0, 9'd30, 9'd0, 9'd10};
    en4 = 1'b1;
    wait_for(1, 0, 500, "t3_done");
    exp_c = '{0, 2, 0, 2, 2, 2};
    exp_v = '{8, 8, 10, 16, 24, 30};
    check("t3_npulse", 64'(q4c.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_ch%0d", i),  64'(qget(q4c, i)), 64'(exp_c[i]));
      check($sformatf("t3_val%0d", i), 64'(qget(q4v, i)), 64'(exp_v[i]));
    end
    check("t3_set_ch1", 64'(set4[1*DW +: DW]), 64'd0);
    check("t3_set_ch3", 64'(set4[3*DW +: DW]), 64'd0);

    // ch0 readback stuck at 0
    rst = 1'b1; tgt4 = '0; stuck4 = 4'b0001;
    repeat (3) @(negedge clk160);
    rst = 1'b0;
    q4c.delete(); q4v.delete();
    tgt4[0 +: DW] = 9'd40;
    wait_for(3, 0, 300, "t4_err_set");
    check("t4_npulse", 64'(q4c.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_ch%0d", i),  64'(qget(q4c, i)), 64'd0);
      check($sformatf("t4_val%0d", i), 64'(qget(q4v, i)), 64'd8);
    end
    repeat (60) @(negedge clk160);
    check("t4_no_more", 64'(q4c.size()), 64'd4);
    check("t4_busy", 64'(busy4), 64'd0);
    check("t4_err_hold", 64'(err4[0]), 64'd1);
    tgt4[0 +: DW] = 9'd41;
    wait_for(4, 5, 100, "t4_resume");
    check("t4_res_ch", 64'(qget(q4c, 4)), 64'd0);
    check("t4_res_val", 64'(qget(q4v, 4)), 64'd8);
    check("t4_err_clr", 64'(err4[0]), 64'd0);

    // reset during SETTLE
    rst = 1'b1; tgt4 = '0; stuck4 = '0;
    repeat (3) @(negedge clk160);
    rst = 1'b0;
    tgt4[1*DW +: DW] = 9'd20;
    wait_for(5, 0, 100, "t6_first_wr");
    @(negedge clk160);
    rst = 1'b1;
    tgt4[0 +: DW] = 9'd20;
    @(negedge clk160);
    check("t6_wr",   64'(wr4),   64'd0);
    check("t6_set",  64'(set4),  64'd0);
    check("t6_busy", 64'(busy4), 64'd0);
    check("t6_err",  64'(err4),  64'd0);
    repeat (3) @(negedge clk160);
    rst = 1'b0;
    q4c.delete(); q4v.delete();
    wait_for(4, 2, 100, "t6_restart");
    check("t6_ch0",  64'(qget(q4c, 0)), 64'd0);
    check("t6_val0", 64'(qget(q4v, 0)), 64'd8);
    check("t6_ch1",  64'(qget(q4c, 1)), 64'd1);
    check("t6_val1", 64'(qget(q4v, 1)), 64'd8);

    check("onehot_wr", 64'(multi_wr), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
